// File: rtl/dmem_lsu.sv
// dmem_lsu: single-outstanding load/store initiator with funct3 width decode, load extension and sub-doubleword read-modify-write
module dmem_lsu #(
  parameter int DATA_WIDTH = 64,
  parameter longint unsigned ADDR_LIMIT = 1048576
) (
  input  logic                  in_clk,
  input  logic                  in_rst_n,
  input  logic                  in_req,
  input  logic                  in_we,
  input  logic [2:0]            in_funct3,
  input  logic [DATA_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_wdata,
  output logic                  out_busy,
  output logic                  out_done,
  output logic                  out_fault,
  output logic [DATA_WIDTH-1:0] out_rdata,
  output logic [DATA_WIDTH-1:0] out_mem_addr,
  output logic [DATA_WIDTH-1:0] out_mem_data,
  output logic                  out_mem_wr_en,
  input  logic [DATA_WIDTH-1:0] in_mem_data
);
  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, DONE} state_t;
  localparam logic [DATA_WIDTH-1:0] MAX_ADDR = DATA_WIDTH'(ADDR_LIMIT - 64'd8);
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, merge_q, rdata_q, ld_ext, st_merge;
  logic [2:0]            f3_q;
  logic                  done_q, fault_q, wr_en_q, accept, req_fault;
  assign accept        = (state_q == IDLE) && in_req;
  assign req_fault     = (in_we ? in_funct3[2] : (in_funct3 == 3'b111)) || (in_addr > MAX_ADDR);
  assign out_busy      = state_q != IDLE;
  assign out_done      = done_q;
  assign out_fault     = fault_q;
  assign out_rdata     = rdata_q;
  assign out_mem_addr  = addr_q;
  assign out_mem_data  = merge_q;
  assign out_mem_wr_en = wr_en_q;
  // Next-state: faults skip memory, SD writes directly, narrower stores read first
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_req) state_d = req_fault ? DONE : !in_we ? LOAD : (in_funct3[1:0] == 2'b11) ? WRITE : RMW_RD;
      LOAD:    state_d = DONE;
      RMW_RD:  state_d = WRITE;
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Sign/zero extension of the raw 8-byte read according to the latched load width
  always_comb begin
    ld_ext = in_mem_data;
    case (f3_q)
      3'b000:  ld_ext = {{(DATA_WIDTH-8){in_mem_data[7]}}, in_mem_data[7:0]};
      3'b001:  ld_ext = {{(DATA_WIDTH-16){in_mem_data[15]}}, in_mem_data[15:0]};
      3'b010:  ld_ext = {{(DATA_WIDTH-32){in_mem_data[31]}}, in_mem_data[31:0]};
      3'b100:  ld_ext = {{(DATA_WIDTH-8){1'b0}}, in_mem_data[7:0]};
      3'b101:  ld_ext = {{(DATA_WIDTH-16){1'b0}}, in_mem_data[15:0]};
      3'b110:  ld_ext = {{(DATA_WIDTH-32){1'b0}}, in_mem_data[31:0]};
      default: ld_ext = in_mem_data;
    endcase
  end
  // Overlay the low store bytes (still held in merge_q) onto the word just read
  always_comb begin
    st_merge = in_mem_data;
    case (f3_q[1:0])
      2'b00:   st_merge[7:0]  = merge_q[7:0];
      2'b01:   st_merge[15:0] = merge_q[15:0];
      2'b10:   st_merge[31:0] = merge_q[31:0];
      default: st_merge       = merge_q;
    endcase
  end
  // State and all outputs registered so write enable and status never glitch
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      f3_q    <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      wr_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_en_q <= state_d == WRITE;
      done_q  <= state_d == DONE;
      fault_q <= accept && req_fault;
      if (accept) begin
        addr_q  <= in_addr;
        f3_q    <= in_funct3;
        merge_q <= in_wdata;
      end
      if (state_q == LOAD) rdata_q <= ld_ext;
      if (state_q == RMW_RD) merge_q <= st_merge;
    end
  end
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: scoreboard bench for dmem_lsu against a small byte-array memory
module tb_dmem_lsu;
  logic        in_clk = 1'b0, in_rst_n = 1'b0, in_req = 1'b0, in_we = 1'b0;
  logic [2:0]  in_funct3 = '0;
  logic [63:0] in_addr = '0, in_wdata = '0, in_mem_data;
  logic        out_busy, out_done, out_fault, out_mem_wr_en;
  logic [63:0] out_rdata, out_mem_addr, out_mem_data;
  logic [7:0]  mem [0:4095];
  typedef struct {logic fault; logic [63:0] rdata;} exp_t;
  exp_t q[$];
  int tests = 0, fails = 0, done_cnt = 0, pushed = 0;

  dmem_lsu #(.DATA_WIDTH(64), .ADDR_LIMIT(1048576)) dut (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .in_req(in_req), .in_we(in_we),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
    .out_busy(out_busy), .out_done(out_done), .out_fault(out_fault),
    .out_rdata(out_rdata), .out_mem_addr(out_mem_addr), .out_mem_data(out_mem_data),
    .out_mem_wr_en(out_mem_wr_en), .in_mem_data(in_mem_data)
  );

  always #5 in_clk = ~in_clk;

  always_comb begin
    in_mem_data = '0;
    for (int i = 0; i < 8; i++) in_mem_data[8*i +: 8] = mem[12'(out_mem_addr[11:0] + 12'(i))];
  end

  always @(posedge in_clk)
    if (out_mem_wr_en)
      for (int i = 0; i < 8; i++) mem[12'(out_mem_addr[11:0] + 12'(i))] <= out_mem_data[8*i +: 8];

  task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  initial forever begin
    exp_t e;
    @(posedge in_clk);
    #1;
    if (out_done) begin
      done_cnt++;
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no pending request");
      end else begin
        e = q.pop_front();
        check("done_fault", 64'(out_fault), 64'(e.fault));
        check("done_rdata", out_rdata, e.rdata);
      end
    end
  end

  task automatic do_op(input string n, input logic we, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic exp_fault, input logic [63:0] exp_rd, input int exp_lat);
    int cyc = 0, wr = 0, w = 0;
    @(negedge in_clk);
    while (out_busy && w < 10) begin
      @(negedge in_clk);
      w++;
    end
    in_req = 1'b1; in_we = we; in_funct3 = f3; in_addr = addr; in_wdata = wdata;
    q.push_back('{exp_fault, exp_rd});
    pushed++;
    @(posedge in_clk);
    for (int k = 1; k <= 20; k++) begin
      #1;
      if (out_mem_wr_en) begin
        wr++;
        check({n, "_wr_addr"}, out_mem_addr, addr);
      end
      if (out_done) begin
        cyc = k;
        break;
      end
      @(posedge in_clk);
    end
    in_req = 1'b0;
    check({n, "_latency"}, 64'(cyc), 64'(exp_lat));
    check({n, "_wr_pulses"}, 64'(wr), (we && !exp_fault) ? 64'd1 : 64'd0);
  endtask

  initial begin
    logic [7:0] keep [0:6];
    int d0, w;
    keep = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    #3;
    check("rst_busy", 64'(out_busy), 64'd0);
    check("rst_done", 64'(out_done), 64'd0);
    check("rst_fault", 64'(out_fault), 64'd0);
    check("rst_wr_en", 64'(out_mem_wr_en), 64'd0);
    check("rst_rdata", out_rdata, 64'd0);
    check("rst_mem_addr", out_mem_addr, 64'd0);
    check("rst_mem_data", out_mem_data, 64'd0);
    @(negedge in_clk);
    @(negedge in_clk);
    in_rst_n = 1'b1;
    do_op("sd",     1, 3'b011, 64'h100, 64'h1122334455667788, 0, 64'h0, 2);
    do_op("ld1",    0, 3'b011, 64'h100, 64'h0, 0, 64'h1122334455667788, 2);
    do_op("sb",     1, 3'b000, 64'h103, 64'hFFFFFFFFFFFFFFAB, 0, 64'h1122334455667788, 3);
    for (int i = 0; i < 7; i++) check($sformatf("sb_keep_%0d", i), 64'(mem[12'h104 + i]), 64'(keep[i]));
    do_op("ld2",    0, 3'b011, 64'h100, 64'h0, 0, 64'h11223344AB667788, 2);
    do_op("lb",     0, 3'b000, 64'h103, 64'h0, 0, 64'hFFFFFFFFFFFFFFAB, 2);
    do_op("lbu",    0, 3'b100, 64'h103, 64'h0, 0, 64'h00000000000000AB, 2);
    do_op("lh",     0, 3'b001, 64'h102, 64'h0, 0, 64'hFFFFFFFFFFFFAB66, 2);
    do_op("lwu",    0, 3'b110, 64'h100, 64'h0, 0, 64'h00000000AB667788, 2);
    do_op("ld_oob", 0, 3'b011, 64'hFFFF9, 64'h0, 1, 64'h00000000AB667788, 1);
    do_op("ld_111", 0, 3'b111, 64'h100, 64'h0, 1, 64'h00000000AB667788, 1);
    do_op("st_1xx", 1, 3'b100, 64'h100, 64'h55, 1, 64'h00000000AB667788, 1);
    do_op("ld_max", 0, 3'b011, 64'hFFFF8, 64'h0, 0, 64'h0, 2);
    do_op("sh",     1, 3'b001, 64'h108, 64'hCAFEBEEF, 0, 64'h0, 3);
    do_op("lhu",    0, 3'b101, 64'h108, 64'h0, 0, 64'h000000000000BEEF, 2);
    do_op("lw",     0, 3'b010, 64'h106, 64'h0, 0, 64'hFFFFFFFFBEEF1122, 2);
    do_op("sw",     1, 3'b010, 64'h200, 64'h1234567887654321, 0, 64'hFFFFFFFFBEEF1122, 3);
    do_op("ld_sw",  0, 3'b011, 64'h200, 64'h0, 0, 64'h0000000087654321, 2);
    check("done_count", 64'(done_cnt), 64'(pushed));
    d0 = done_cnt;
    @(negedge in_clk);
    in_req = 1'b1; in_we = 1'b1; in_funct3 = 3'b000; in_addr = 64'h300; in_wdata = 64'hCD;
    w = 0;
    @(posedge in_clk);
    #1;
    while (!out_mem_wr_en && w < 10) begin
      @(posedge in_clk);
      #1;
      w++;
    end
    check("rst_mid_wr_seen", 64'(out_mem_wr_en), 64'd1);
    #1 in_rst_n = 1'b0;
    #1;
    check("rst_mid_wr_en", 64'(out_mem_wr_en), 64'd0);
    check("rst_mid_busy", 64'(out_busy), 64'd0);
    check("rst_mid_rdata", out_rdata, 64'd0);
    in_req = 1'b0;
    @(negedge in_clk);
    in_rst_n = 1'b1;
    repeat (4) @(negedge in_clk);
    check("rst_no_write", 64'(mem[12'h300]), 64'd0);
    check("rst_no_retry", 64'(done_cnt), 64'(d0));
    check("rst_idle", 64'(out_busy), 64'd0);
    check("queue_empty", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store initiator that sits between the RV64IF execute stage and the byte-addressed data memory. Accepts one load or store request at a time and decodes RISC-V funct3 widths. Performs sign or zero extension on loads and read-modify-write on sub-doubleword stores, because the memory always reads and writes 8 consecutive bytes starting at the supplied address. Drives the memory's level-sensitive write enable from registers only, so the memory never sees a glitch.

## Interface
- DATA_WIDTH, 64, data and address width.
- ADDR_LIMIT, 1048576, memory size in bytes; the highest legal request address is ADDR_LIMIT-8.
- in_clk  input  1  rising-edge clock.
- in_rst_n  input  1  asynchronous, active-low reset.
- in_req  input  1  request valid; sampled only in IDLE.
- in_we  input  1  1 = store, 0 = load.
- in_funct3  input  3  RISC-V load/store funct3.
- in_addr  input  64  byte address.
- in_wdata  input  64  store data, right-aligned.
- out_busy  output  1  high in every state except IDLE.
- out_done  output  1  one-cycle completion pulse.
- out_fault  output  1  valid with out_done; request rejected, no memory access.
- out_rdata  output  64  extended load result; valid with out_done and held until the next load completes.
- out_mem_addr  output  64  to memory in_addr.
- out_mem_data  output  64  to memory in_data.
- out_mem_wr_en  output  1  to memory in_wr_en.
- in_mem_data  input  64  from memory out_data; combinational read.

## Operation
- Load funct3 encodings: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU. 111 is illegal.
- Store funct3 encodings: 000 SB, 001 SH, 010 SW, 011 SD. 1xx is illegal.
- Fault conditions: illegal funct3, or in_addr > ADDR_LIMIT-8. A faulting request goes IDLE->DONE with out_fault=1 and produces no wr_en pulse. out_rdata is unchanged.
- FSM states: IDLE, LOAD, RMW_RD, WRITE, DONE.
  - IDLE + in_req: latch addr, we, funct3 and wdata. Then go to FAULT->DONE, load->LOAD, SD->WRITE, or SB/SH/SW->RMW_RD.
  - LOAD: capture in_mem_data at end of cycle, then go to DONE.
  - RMW_RD: capture in_mem_data into a merge register, replacing low 1/2/4 bytes with in_wdata[7:0]/[15:0]/[31:0]. Then go to WRITE.
  - WRITE: out_mem_wr_en=1, out_mem_data = merged word, or in_wdata for SD. Then go to DONE.
  - DONE: out_done=1, then go to IDLE.
- Load extension: LB/LH/LW sign-extend bit 7/15/31. LBU/LHU/LWU zero-extend. LD passes through.
- out_mem_addr is driven with the latched address from the cycle after acceptance through DONE. It holds its value in IDLE.
- out_mem_addr is never changed while out_mem_wr_en=1.
- in_req while busy is ignored; the requester holds the request until out_done.

## Timing
- Reset (async, immediate): state=IDLE and all outputs 0, including out_mem_wr_en. A reset mid-WRITE drops wr_en without waiting for a clock. No partial retry occurs after reset.
- Cycle numbering: request accepted at edge E0.
  - Load: LOAD in cycle 1, out_done in cycle 2. Latency is 2 cycles.
  - SD: WRITE in cycle 1, done in cycle 2.
  - SB/SH/SW: RMW_RD in cycle 1, WRITE in cycle 2, done in cycle 3.
  - Fault: done in cycle 1.
- out_mem_wr_en is high for exactly one cycle per store and is registered. It falls at the same edge that enters DONE, while the address remains stable.
- Back-to-back: a new in_req can be accepted in the cycle after DONE, i.e. one IDLE cycle minimum between requests.
- out_fault, out_done and out_rdata are registered. out_fault is 0 except in a faulting DONE.

## Test plan
- SD at 0x100 with 0x1122334455667788, then LD at 0x100 -> wr_en high for 1 cycle, done at cycle 2; LD returns 0x1122334455667788 at cycle 2.
- SB 0xAB at 0x103 over that data, then LD 0x100 -> 0x11223344AB667788. Check that the RMW path takes 3 cycles and that bytes 0x104-0x10A are unchanged.
- LB / LBU at 0x103 -> 0xFFFFFFFFFFFFFFAB and 0x00000000000000AB.
- LH at 0x102 -> 0xFFFFFFFFFFFFAB66. LWU at 0x100 -> 0x00000000AB667788.
- LD at ADDR_LIMIT-7, and a load with funct3=111 -> out_fault=1 at cycle 1, no wr_en, out_rdata unchanged.
- Assert in_rst_n=0 during WRITE of an SB -> out_mem_wr_en falls with no clock edge and state is IDLE. A second in_req while busy is ignored, producing exactly one out_done.
